// File: rtl/mem_responder.sv
// Memory-mapped responder: 256x16 RAM, switch input register and LED output register.
// Optional sticky bus error flag is enabled with `define MEM_BUS_ERR_EN.
module mem_responder #(
  parameter logic [8:0] LED_ADDR = 9'h100,
  parameter logic [8:0] SW_ADDR  = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  input  logic [7:0]  sw,
  output logic [7:0]  ledr,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  state_t      state;
  logic [15:0] mem [256];
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [8:0]  wr_addr;
  logic        is_ram;
  logic        is_sw;
  logic        is_led;
  logic        do_read;
  logic        do_write;
  logic [15:0] rd_mux;

  assign is_ram  = ~mem_addr[8];
  assign is_sw   = (mem_addr == SW_ADDR);
  assign is_led  = (mem_addr == LED_ADDR);
  assign do_read = (mem_cmd == CMD_READ);
  // A held WRITE commits once; only a new address inside WRITE commits again.
  assign do_write = (mem_cmd == CMD_WRITE) &&
                    ((state != S_WRITE) || (mem_addr != wr_addr));

  always_comb begin
    rd_mux = 16'h0000;
    if (is_ram)
      rd_mux = mem[mem_addr[7:0]];
    else if (is_sw)
      rd_mux = {8'h00, sw_sync};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      read_data <= 16'h0000;
      ledr      <= 8'h00;
      sw_meta   <= 8'h00;
      sw_sync   <= 8'h00;
      wr_addr   <= 9'h000;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      case (mem_cmd)
        CMD_READ:  state <= S_READ;
        CMD_WRITE: state <= S_WRITE;
        default:   state <= S_IDLE;
      endcase
      if (do_read)
        read_data <= rd_mux;
      if (do_write) begin
        wr_addr <= mem_addr;
        if (is_led)
          ledr <= write_data[7:0];
      end
    end
  end

  // RAM keeps its contents through reset; the reset arm only blocks writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else if (do_write && is_ram) begin
      mem[mem_addr[7:0]] <= write_data;
    end
  end

`ifdef MEM_BUS_ERR_EN
  logic err_now;

  always_comb begin
    err_now = 1'b0;
    if (mem_cmd == CMD_ILLEGAL)
      err_now = 1'b1;
    else if ((mem_cmd == CMD_READ || mem_cmd == CMD_WRITE) && !is_ram && !is_sw && !is_led)
      err_now = 1'b1;
    else if (mem_cmd == CMD_WRITE && is_sw)
      err_now = 1'b1;
    else if (mem_cmd == CMD_READ && is_led)
      err_now = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus_err <= 1'b0;
    else if (err_now)
      bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// against a transaction-level model (memory array, LED byte, switch history).
module tb_mem_responder;

  localparam logic [8:0] LED_A = 9'h100;
  localparam logic [8:0] SW_A  = 9'h140;
  localparam logic [1:0] C_NONE = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_BAD = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mem_cmd = C_NONE;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [15:0] read_data;
  logic [7:0]  sw = '0;
  logic [7:0]  ledr;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_mem [256];
  logic [15:0] m_rd;
  logic [7:0]  m_led;
  logic        m_err;
  logic [7:0]  m_sw_hist [2];
  logic        m_in_write;
  logic [8:0]  m_last_wr;

  mem_responder #(.LED_ADDR(LED_A), .SW_ADDR(SW_A)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .sw(sw), .ledr(ledr),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_mapped(input logic [8:0] a);
    return (a < 9'd256) || (a == SW_A) || (a == LED_A);
  endfunction

  task automatic model_reset();
    m_rd = '0; m_led = '0; m_err = 1'b0;
    m_sw_hist[0] = '0; m_sw_hist[1] = '0;
    m_in_write = 1'b0; m_last_wr = '0;
  endtask

  // One clock edge worth of behaviour, from the command rules.
  task automatic model_edge(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                            input logic [7:0] sw_now);
    if (c == C_RD) begin
      if (a < 9'd256)  m_rd = m_mem[a[7:0]];
      else if (a == SW_A) m_rd = {8'h00, m_sw_hist[1]};
      else m_rd = 16'h0000;
    end
    if (c == C_WR && !(m_in_write && a == m_last_wr)) begin
      m_last_wr = a;
      if (a < 9'd256) m_mem[a[7:0]] = d;
      else if (a == LED_A) m_led = d[7:0];
    end
    m_in_write = (c == C_WR);
`ifdef MEM_BUS_ERR_EN
    if (c == C_BAD || ((c == C_RD || c == C_WR) && !is_mapped(a)) ||
        (c == C_WR && a == SW_A) || (c == C_RD && a == LED_A))
      m_err = 1'b1;
`endif
    m_sw_hist[1] = m_sw_hist[0];
    m_sw_hist[0] = sw_now;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd"},  read_data, m_rd);
    check({tag, ".led"}, {8'h00, ledr}, {8'h00, m_led});
    check({tag, ".err"}, {15'h0, bus_err}, {15'h0, m_err});
  endtask

  task automatic cyc(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_cmd = c; mem_addr = a; write_data = d;
    @(posedge clk);
    model_edge(c, a, d, sw);
    #1;
    check_all("step");
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // fill RAM so every later read has defined data
    for (int i = 0; i < 256; i++) cyc(C_WR, 9'(i), 16'($urandom));
    cyc(C_NONE, '0, '0);

    // write held two cycles, second cycle carries new data that must not commit
    cyc(C_WR, 9'h005, 16'hBEEF);
    cyc(C_WR, 9'h005, 16'hDEAD);
    cyc(C_RD, 9'h005, '0);
    check("beef_rd1", read_data, 16'hBEEF);
    cyc(C_RD, 9'h005, '0);
    check("beef_rd2", read_data, 16'hBEEF);

    sw = 8'hA5;
    repeat (3) cyc(C_NONE, '0, '0);
    cyc(C_RD, SW_A, '0);
    check("sw_rd", read_data, 16'h00A5);
    cyc(C_WR, LED_A, 16'h1234);
    check("led_wr", {8'h00, ledr}, 16'h0034);
    cyc(C_NONE, '0, '0);

    cyc(C_WR, 9'h010, 16'h1010);
    cyc(C_WR, 9'h011, 16'h1111);
    cyc(C_RD, 9'h010, '0);
    check("b2b_16", read_data, 16'h1010);
    cyc(C_RD, 9'h011, '0);
    check("b2b_17", read_data, 16'h1111);

    cyc(C_WR, 9'h020, 16'h0001);
    cyc(C_WR, 9'h021, 16'h0002);
    cyc(C_RD, 9'h020, '0);
    check("ww_20", read_data, 16'h0001);
    cyc(C_RD, 9'h021, '0);
    check("ww_21", read_data, 16'h0002);

    cyc(C_RD, 9'h1FF, '0);
    check("unmapped_rd", read_data, 16'h0000);
    cyc(C_BAD, 9'h021, 16'hFFFF);
    check("illegal_rd", read_data, 16'h0000);
    check("illegal_led", {8'h00, ledr}, 16'h0034);
    cyc(C_RD, 9'h021, '0);
    check("illegal_ram", read_data, 16'h0002);
`ifdef MEM_BUS_ERR_EN
    check("err_sticky", {15'h0, bus_err}, 16'h0001);
`else
    check("err_off", {15'h0, bus_err}, 16'h0000);
`endif

    // reset in the middle of a write
    cyc(C_WR, 9'h030, 16'h7777);
    cyc(C_NONE, '0, '0);
    cyc(C_RD, 9'h030, '0);
    check("pre_rst", read_data, 16'h7777);
    @(negedge clk);
    mem_cmd = C_WR; mem_addr = 9'h030; write_data = 16'hAAAA;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_async_rd", read_data, 16'h0000);
    check("rst_async_led", {8'h00, ledr}, 16'h0000);
    check("rst_async_err", {15'h0, bus_err}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_cmd = C_NONE;
    m_sw_hist[0] = '0; m_sw_hist[1] = '0;
    cyc(C_RD, 9'h030, '0);
    check("rst_no_commit", read_data, 16'h7777);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [8:0] a;
      logic [1:0] c;
      case ($urandom_range(0, 5))
        0, 1: a = 9'($urandom_range(0, 7));
        2:    a = SW_A;
        3:    a = LED_A;
        4:    a = 9'h1FF;
        default: a = 9'($urandom);
      endcase
      c = 2'($urandom);
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      cyc(c, a, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter LED_ADDR, default 9'h100: the write-only LED register address.
REQ-002 The block SHALL have parameter SW_ADDR, default 9'h140: the read-only switch register address.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port mem_cmd, input, 2 bits: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 illegal.
REQ-006 The block SHALL have port mem_addr, input, 9 bits: the word address from the CPU.
REQ-007 The block SHALL have port write_data, input, 16 bits: the CPU store data, sampled on WRITE.
REQ-008 The block SHALL have port read_data, output, 16 bits, registered: the response data, driven to the CPU "in" port.
REQ-009 The block SHALL have port sw, input, 8 bits: asynchronous board switches.
REQ-010 The block SHALL have port ledr, output, 8 bits, registered: the LED register.
REQ-011 The block SHALL have port bus_err, output, 1 bit: the sticky error flag (see Configuration).

Function
REQ-012 The address map SHALL be: 9'h000-9'h0FF RAM (256x16); SW_ADDR switches; LED_ADDR LEDs; all other addresses unmapped.
REQ-013 The FSM SHALL have the states IDLE, READ and WRITE, evaluated at each rising clk edge on (mem_cmd, mem_addr).
REQ-014 Transitions from any state SHALL be:
- READ command: go to READ.
- WRITE command: go to WRITE.
- NONE or illegal command: go to IDLE.
REQ-015 Read latency SHALL be one edge: at the edge sampling READ with address A, read_data loads data(A), valid for the whole following cycle; the CPU's two-cycle READ is thereby satisfied in its second cycle.
REQ-016 Read data sources SHALL be: RAM read returns mem[A[7:0]]; a SW_ADDR read returns {8'h00, sw_sync}; a LED_ADDR read or an unmapped read returns 16'h0000.
REQ-017 read_data SHALL hold its last value in IDLE and WRITE, and SHALL update only on edges sampling READ.
REQ-018 While in READ, a READ sampled at a changed address SHALL start a new read, with the same one-edge latency.
REQ-019 A write SHALL commit exactly once per command: at the edge entering WRITE, or at an edge in WRITE where mem_addr differs from the captured write address.
- Repeated WRITE cycles at the same address SHALL NOT re-commit.
REQ-020 Write targets SHALL be: RAM stores write_data; LED_ADDR loads ledr <= write_data[7:0]; SW_ADDR and unmapped writes are discarded.
REQ-021 A RAM read immediately after a write to the same address SHALL return the new data, with no stale-data hazard.
REQ-022 sw SHALL pass through a 2-flop synchronizer; sw_sync is the second stage.
REQ-023 An illegal command (2'b11) SHALL cause no RAM, LED or read_data change.

Reset
REQ-024 While reset is high, the block SHALL immediately hold: state IDLE, read_data 16'h0000, ledr 8'h00, bus_err 0, synchronizer 0, captured write address 0.
REQ-025 RAM contents SHALL be unaffected by reset.
REQ-026 A WRITE present at an edge while reset is high SHALL NOT commit.
REQ-027 After reset deasserts, the first sampled READ or WRITE SHALL be treated as a new command.

Configuration
REQ-028 With macro MEM_BUS_ERR_EN defined, bus_err SHALL be set at any edge sampling an illegal command, or a READ or WRITE to an unmapped address, a write to SW_ADDR, or a read of LED_ADDR.
- bus_err SHALL stay set until reset.
- Data behaviour SHALL be unchanged.
REQ-029 Without MEM_BUS_ERR_EN, bus_err SHALL be constant 0 and no error logic is present.

Verification
REQ-030 The bench SHALL cover: reset; WRITE 9'h005 data 16'hBEEF for 2 cycles; then READ 9'h005 for 2 cycles -> read_data 16'hBEEF in the 2nd READ cycle, exactly one RAM commit.
REQ-031 The bench SHALL cover: sw=8'hA5 held 3 cycles; READ SW_ADDR -> read_data 16'h00A5; then WRITE LED_ADDR data 16'h1234 -> ledr 8'h34 next cycle.
REQ-032 The bench SHALL cover: back-to-back READ 9'h010 then READ 9'h011 with no NONE cycle -> read_data shows mem[16] then mem[17] on consecutive edges.
REQ-033 The bench SHALL cover: WRITE 9'h020 data 16'h0001 then WRITE 9'h021 data 16'h0002 consecutively -> both locations updated, one commit each.
REQ-034 The bench SHALL cover: reset asserted mid-WRITE to 9'h030 (old value 16'h7777) -> mem[48] stays 16'h7777, read_data and ledr return to 0 without a clock edge.
REQ-035 The bench SHALL cover: READ 9'h1FF and mem_cmd=2'b11 -> read_data 16'h0000, no state change; bus_err=1 with MEM_BUS_ERR_EN and stays 1 until reset; bus_err=0 without the macro.
